// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared types and constants for the Hack CPU sequencer
//
// Purpose: sequencer state encoding, instruction field positions and the
// word/address widths used by hack_cpu_ctrl and its sub-module.
// Ports: none (package).
package hack_pkg;

  localparam int WORD_W   = 16;
  localparam int ADDR_W   = 15;

  // Instruction field positions (MSB of each field)
  localparam int A_BIT    = 12;
  localparam int COMP_MSB = 11;
  localparam int DEST_MSB = 5;
  localparam int JMP_MSB  = 2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MEM   = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

endpackage

// File: rtl/hack_jump_eval.sv
// rtl/hack_jump_eval.sv - jump condition evaluation from ALU flags
//
// Purpose: decides whether a C-instruction jump is taken.
// Ports:
//   j     in  3  jump field {lt, eq, gt}
//   zr    in  1  ALU result is zero
//   ng    in  1  ALU result is negative
//   taken out 1  jump taken
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  // "gt" means strictly positive: neither negative nor zero
  assign taken = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// rtl/hack_cpu_ctrl.sv - multi-cycle Hack CPU sequencer upstream of the ALU
//
// Purpose: fetches instructions, holds A/D/PC, drives the external ALU for
// C-instructions and performs writeback to A/D/M and jump resolution.
// Optional build macro CPU_ALU_REG_EN: registers the ALU result and flags at
// the end of EXEC and performs writeback from them in an extra WB state.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   run                          allow the next fetch
//   imem_req/addr/valid/data     instruction fetch interface
//   dmem_addr/re/rdata/we/wdata  data memory interface
//   alu_x/y, alu_zx..alu_no      ALU operands and control bits
//   alu_out/zr/ng                ALU result and flags
//   instr_done                   retire pulse
//   pc                           current PC (debug)
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 15'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [WORD_W-1:0] imem_data,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_re,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_wdata,
  output logic [WORD_W-1:0] alu_x,
  output logic [WORD_W-1:0] alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic              instr_done,
  output logic [ADDR_W-1:0] pc
);

  state_t            r_state;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_d;
  logic [WORD_W-1:0] r_m;
  logic [ADDR_W-1:0] r_pc;

  logic              w_fetch;
  logic              w_exec;
  logic              w_wb;
  logic              w_dest_m;
  logic              w_zr;
  logic              w_ng;
  logic              w_take;
  logic [WORD_W-1:0] w_res;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_unused_ir_bits;

  assign w_fetch  = (r_state == FETCH);
  assign w_exec   = (r_state == EXEC);
  assign w_dest_m = r_ir[DEST_MSB-2];
  assign w_pc_inc = r_pc + ADDR_W'(1);   // wraps 7FFF -> 0

  // Bits 14:13 of a C-instruction carry no meaning; bit 15 is consumed at fetch.
  assign w_unused_ir_bits = ^r_ir[WORD_W-1:13];

`ifdef CPU_ALU_REG_EN
  logic [WORD_W-1:0] r_alu_out;
  logic              r_alu_zr;
  logic              r_alu_ng;

  assign w_res = r_alu_out;
  assign w_zr  = r_alu_zr;
  assign w_ng  = r_alu_ng;
  assign w_wb  = (r_state == WB);
`else
  assign w_res = alu_out;
  assign w_zr  = alu_zr;
  assign w_ng  = alu_ng;
  assign w_wb  = w_exec;
`endif

  hack_jump_eval u_jump (
    .j     (r_ir[JMP_MSB -: 3]),
    .zr    (w_zr),
    .ng    (w_ng),
    .taken (w_take)
  );

  // Strobes are forced low while rst is high, independent of state.
  assign imem_req   = ~rst & w_fetch & run;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign dmem_addr  = r_a[ADDR_W-1:0];
  assign dmem_re    = ~rst & (r_state == MEM);
  assign dmem_we    = ~rst & w_wb & w_dest_m;
  assign dmem_wdata = (w_wb & w_dest_m) ? w_res : '0;

  assign alu_x = w_exec ? r_d : '0;
  assign alu_y = w_exec ? (r_ir[A_BIT] ? r_m : r_a) : '0;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} =
         w_exec ? r_ir[COMP_MSB -: 6] : 6'b0;

  // A-instructions retire on the fetch edge itself.
  assign instr_done = ~rst & ((imem_req & imem_valid & ~imem_data[WORD_W-1]) | w_wb);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_d     <= '0;
      r_m     <= '0;
`ifdef CPU_ALU_REG_EN
      r_alu_out <= '0;
      r_alu_zr  <= 1'b0;
      r_alu_ng  <= 1'b0;
`endif
    end else begin
      case (r_state)
        FETCH: begin
          if (run && imem_valid) begin
            r_ir <= imem_data;
            if (!imem_data[WORD_W-1]) begin
              r_a  <= {1'b0, imem_data[ADDR_W-1:0]};
              r_pc <= w_pc_inc;
            end else begin
              r_state <= imem_data[A_BIT] ? MEM : EXEC;
            end
          end
        end
        MEM: begin
          r_m     <= dmem_rdata;
          r_state <= EXEC;
        end
        EXEC: begin
`ifdef CPU_ALU_REG_EN
          r_alu_out <= alu_out;
          r_alu_zr  <= alu_zr;
          r_alu_ng  <= alu_ng;
          r_state   <= WB;
`else
          r_state   <= FETCH;
`endif
        end
        default: r_state <= FETCH;
      endcase

      // Jump target is the A value from before this instruction's own A write.
      if (w_wb) begin
        if (r_ir[DEST_MSB])   r_a <= w_res;
        if (r_ir[DEST_MSB-1]) r_d <= w_res;
        r_pc <= w_take ? r_a[ADDR_W-1:0] : w_pc_inc;
      end
    end
  end

endmodule
